dmem_sram_ctrl: RTL and testbench
=================================

// Module: dmem_sram_ctrl
// PURPOSE
// - Data-memory controller directly downstream of the pipeline M stage.
// - Consumes the M-stage address, write data and byte enables; returns read_data_M and data_mem_ack.
// - Serves each 32-bit access as two 16-bit halves on the board's asynchronous SRAM.
// - The hazard unit stalls the pipeline until data_mem_ack pulses.
// PARAMETERS
// - AW           18  SRAM halfword address width.
// - WAIT_CYCLES  1   Cycles per half-phase (>=1). SRAM strobes are held for the whole phase.
// PORTS
// - clk          in   1   System clock.
// - reset        in   1   Synchronous, active-high.
// - req_M        in   1   M-stage memory access pending.
// - we_M         in   1   1 = store, 0 = load.
// - addr_M       in   32  Byte address. Uses bits [AW:2]; bits [1:0] and bits above AW are ignored.
// - wdata_M      in   32  Lane-aligned store data (write_data_M).
// - byte_en_M    in   4   Store byte lanes. Bit0 = [7:0]. Ignored for loads.
// - read_data_M  out  32  Full word read. Held until the next load completes.
// - data_mem_ack out  1   One-cycle completion pulse.
// - sram_addr    out  AW  Halfword address.
// - sram_dq_out  out  16  Write data to the pad.
// - sram_dq_in   in   16  Read data from the pad.
// - sram_dq_oe   out  1   Pad output enable. High only during write phases.
// - sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out 1 each. Active-low strobes.
// BEHAVIOUR
// - Reset values: read_data_M=0, data_mem_ack=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0; all *_n=1; state IDLE.
// - States and transitions:
//   - IDLE: req_M=1 latches addr/wdata/be/we at the edge. Next state is LO; HI if this is a store with be[1:0]=0; DONE if this is a store with be=0.
//   - LO: sram_addr={addr[AW:2],1'b0}, data lanes [15:0]. Lasts WAIT_CYCLES cycles.
//     - Next is HI; for a store with be[3:2]=0, next is DONE.
//   - HI: sram_addr={addr[AW:2],1'b1}, data lanes [31:16]. Lasts WAIT_CYCLES cycles. Next is DONE.
//   - DONE: data_mem_ack=1 for exactly this cycle. read_data_M is updated at the preceding edge for loads. Next is IDLE.
// - Loads: ce_n=oe_n=0, ub_n=lb_n=0, we_n=1, dq_oe=0 in both phases. sram_dq_in is sampled on the last cycle of each phase.
// - Stores: ce_n=we_n=0, oe_n=1, dq_oe=1.
//   - lb_n=~be[0] and ub_n=~be[1] in LO; lb_n=~be[2] and ub_n=~be[3] in HI.
//   - A phase whose two enables are both 0 is skipped.
// - Timing: cycle 0 is the IDLE cycle where req_M is first seen.
//   - Full access: ack in cycle 2*WAIT_CYCLES+1.
//   - Single-half store: ack in cycle WAIT_CYCLES+1.
//   - be=0 store: ack in cycle 1.
// - Handshake: req_M and operands stay stable until ack.
//   - In the cycle after ack, req_M is either low or a new access. IDLE accepts it the same cycle, with no bubble.
//   - Operand changes between acceptance and ack are ignored, because the latched copies are used.
// - Between accesses, IDLE drives all strobes high and dq_oe=0.
// - Reset mid-access: state returns to IDLE at that edge; no ack. Strobes and dq_oe are deasserted in the following cycle. read_data_M=0.
// CONFIGURATION
// - DMEM_LAST_READ_BUF_EN defined: adds a one-entry buffer holding valid, word tag addr[AW:2] and 32-bit data.
//   - Filled on every completed load.
//   - Load hit (valid and tag match): IDLE goes straight to DONE, giving ack in cycle 1. No strobe asserted. read_data_M = buffered data.
//   - A store to a matching tag clears valid when it is accepted.
//   - reset clears valid.
// - Undefined: no buffer; every load performs both SRAM phases.
// TESTING
// - Reset -> all *_n=1, dq_oe=0, ack=0, read_data_M=0 on the following cycle.
// - W=1, store 0x100, data 0xDEADBEEF, be=1111:
//   - Cycle 1: addr=0x080, dq_out=0xBEEF, ub/lb=0.
//   - Cycle 2: addr=0x081, dq_out=0xDEAD.
//   - Cycle 3: ack.
// - W=1, load 0x100 with the SRAM model returning the stored data -> read_data_M=0xDEADBEEF, ack in cycle 3, we_n=1 throughout.
// - W=2, store 0x104, data 0x00AA0000, be=0100 -> only HI: addr=0x083, lb_n=0, ub_n=1, dq_out=0x00AA in cycles 1-2; ack in cycle 3.
// - Back-to-back: a new load presented in the cycle after ack is accepted immediately.
// - Reset during HI -> no ack; strobes high next cycle.
// - DMEM_LAST_READ_BUF_EN: second load of 0x100 -> ack in cycle 1, ce_n=1 throughout; after a store to 0x100, the next load uses the SRAM (ack in cycle 3).

Source files
------------

// File: rtl/dmem_sram_ctrl_if.sv
// rtl/dmem_sram_ctrl_if.sv - M-stage data-memory request/response bus
interface dmem_sram_ctrl_if;
  logic        req_M;
  logic        we_M;
  logic [31:0] addr_M;
  logic [31:0] wdata_M;
  logic [3:0]  byte_en_M;
  logic [31:0] read_data_M;
  logic        data_mem_ack;

  modport master (
    output req_M, we_M, addr_M, wdata_M, byte_en_M,
    input  read_data_M, data_mem_ack
  );

  modport slave (
    input  req_M, we_M, addr_M, wdata_M, byte_en_M,
    output read_data_M, data_mem_ack
  );
endinterface

// File: rtl/dmem_sram_ctrl.sv
// rtl/dmem_sram_ctrl.sv - 32-bit data memory over a 16-bit async SRAM, two halfword phases per word
// Optional last-read buffer: DMEM_LAST_READ_BUF_EN
module dmem_sram_ctrl #(
  parameter int AW          = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  dmem_sram_ctrl_if.slave bus,
  output logic [AW-1:0] sram_addr,
  output logic [15:0]   sram_dq_out,
  input  logic [15:0]   sram_dq_in,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n
);

  localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          phase_last;
  logic [AW-2:0] a_word;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;
  logic          a_we;
  logic [15:0]   rd_lo;
  logic [31:0]   rdata;
  logic          buf_hit;
  logic [31:0]   hit_data;

  wire [AW-2:0] req_word    = bus.addr_M[AW:2];
  wire          unused_addr = &{1'b0, bus.addr_M[31:AW+1], bus.addr_M[1:0]};

  assign bus.read_data_M  = rdata;
  assign bus.data_mem_ack = (state == DONE);

`ifdef DMEM_LAST_READ_BUF_EN
  logic          buf_valid;
  logic [AW-2:0] buf_tag;
  logic [31:0]   buf_data;

  assign buf_hit  = buf_valid && (buf_tag == req_word);
  assign hit_data = buf_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == IDLE && bus.req_M && bus.we_M && buf_hit) begin
      buf_valid <= 1'b0;
    end else if (state == HI && phase_last && !a_we) begin
      buf_valid <= 1'b1;
      buf_tag   <= a_word;
      buf_data  <= {sram_dq_in, rd_lo};
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    phase_last  = (cnt == LAST);
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    case (state)
      IDLE: begin
        if (bus.req_M) begin
          if (bus.we_M) begin
            if (bus.byte_en_M == 4'b0000)      state_next = DONE;
            else if (bus.byte_en_M[1:0] == 2'b00) state_next = HI;
            else                                state_next = LO;
          end else begin
            state_next = buf_hit ? DONE : LO;
          end
        end
      end
      LO, HI: begin
        sram_addr = {a_word, state == HI};
        sram_ce_n = 1'b0;
        if (a_we) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HI) ? a_wdata[31:16] : a_wdata[15:0];
          sram_lb_n   = (state == HI) ? ~a_be[2] : ~a_be[0];
          sram_ub_n   = (state == HI) ? ~a_be[3] : ~a_be[1];
        end else begin
          sram_oe_n = 1'b0;
          sram_ub_n = 1'b0;
          sram_lb_n = 1'b0;
        end
        // A store whose upper lanes are all off finishes after the low phase
        if (phase_last) begin
          if (state == HI || (a_we && a_be[3:2] == 2'b00)) state_next = DONE;
          else                                             state_next = HI;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      a_word  <= '0;
      a_wdata <= '0;
      a_be    <= '0;
      a_we    <= 1'b0;
      rd_lo   <= '0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && bus.req_M) begin
        a_word  <= req_word;
        a_wdata <= bus.wdata_M;
        a_be    <= bus.byte_en_M;
        a_we    <= bus.we_M;
        if (!bus.we_M && buf_hit) rdata <= hit_data;
      end
      if (state == LO || state == HI) cnt <= phase_last ? '0 : cnt + 1'b1;
      if (state == LO && phase_last && !a_we) rd_lo <= sram_dq_in;
      if (state == HI && phase_last && !a_we) rdata <= {sram_dq_in, rd_lo};
    end
  end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// tb/tb_dmem_sram_ctrl.sv - directed bench for dmem_sram_ctrl at WAIT_CYCLES 1 and 2
module tb_dmem_sram_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic last_ce_seen;

  dmem_sram_ctrl_if bus1();
  dmem_sram_ctrl_if bus2();

  logic [17:0] sram_addr1, sram_addr2;
  logic [15:0] dq_out1, dq_in1, dq_out2, dq_in2;
  logic dq_oe1, ce_n1, oe_n1, we_n1, ub_n1, lb_n1;
  logic dq_oe2, ce_n2, oe_n2, we_n2, ub_n2, lb_n2;

  dmem_sram_ctrl #(.AW(18), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1), .sram_dq_oe(dq_oe1),
    .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1), .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
  );

  dmem_sram_ctrl #(.AW(18), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .sram_addr(sram_addr2), .sram_dq_out(dq_out2), .sram_dq_in(dq_in2), .sram_dq_oe(dq_oe2),
    .sram_ce_n(ce_n2), .sram_oe_n(oe_n2), .sram_we_n(we_n2), .sram_ub_n(ub_n2), .sram_lb_n(lb_n2)
  );

  // Async SRAM models with byte lanes
  logic [15:0] mem1 [0:255] = '{default: 16'h0};
  logic [15:0] mem2 [0:255] = '{default: 16'h0};

  always @(posedge clk) begin
    if (!ce_n1 && !we_n1) begin
      if (!lb_n1) mem1[sram_addr1[7:0]][7:0]  <= dq_out1[7:0];
      if (!ub_n1) mem1[sram_addr1[7:0]][15:8] <= dq_out1[15:8];
    end
    if (!ce_n2 && !we_n2) begin
      if (!lb_n2) mem2[sram_addr2[7:0]][7:0]  <= dq_out2[7:0];
      if (!ub_n2) mem2[sram_addr2[7:0]][15:8] <= dq_out2[15:8];
    end
  end

  assign dq_in1 = (!ce_n1 && !oe_n1) ? mem1[sram_addr1[7:0]] : 16'h0;
  assign dq_in2 = (!ce_n2 && !oe_n2) ? mem2[sram_addr2[7:0]] : 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access1(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int exp_cyc, input logic [31:0] exp_rd);
    int   cyc      = 0;
    logic ce_seen  = 1'b0;
    logic we_seen  = 1'b0;
    bus1.req_M     = 1'b1;
    bus1.we_M      = we;
    bus1.addr_M    = addr;
    bus1.wdata_M   = wdata;
    bus1.byte_en_M = be;
    while (bus1.data_mem_ack !== 1'b1 && cyc < 12) begin
      if (!ce_n1) ce_seen = 1'b1;
      if (!we_n1) we_seen = 1'b1;
      tick();
      cyc++;
    end
    check({tag, "_ack_cycle"}, cyc, exp_cyc);
    if (!we) begin
      check({tag, "_rdata"}, bus1.read_data_M, exp_rd);
      check({tag, "_we_n_high"}, we_seen, 1'b0);
    end
    last_ce_seen = ce_seen;
    tick();
  endtask

  initial begin
    int cyc;
    bus1.req_M = 1'b0; bus1.we_M = 1'b0; bus1.addr_M = '0; bus1.wdata_M = '0; bus1.byte_en_M = '0;
    bus2.req_M = 1'b0; bus2.we_M = 1'b0; bus2.addr_M = '0; bus2.wdata_M = '0; bus2.byte_en_M = '0;

    tick();
    check("rst_strobes", {ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1}, 6'b111110);
    check("rst_ack", bus1.data_mem_ack, 1'b0);
    check("rst_rdata", bus1.read_data_M, 32'h0);
    check("rst_addr", sram_addr1, 18'h0);
    reset = 1'b0;
    tick();

    // Full-word store, phase by phase
    bus1.req_M = 1'b1; bus1.we_M = 1'b1; bus1.addr_M = 32'h100;
    bus1.wdata_M = 32'hDEADBEEF; bus1.byte_en_M = 4'b1111;
    check("st_c0_ack", bus1.data_mem_ack, 1'b0);
    tick();
    check("st_c1_addr", sram_addr1, 18'h080);
    check("st_c1_dq", dq_out1, 16'hBEEF);
    check("st_c1_strobes", {ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1}, 6'b010001);
    tick();
    check("st_c2_addr", sram_addr1, 18'h081);
    check("st_c2_dq", dq_out1, 16'hDEAD);
    check("st_c2_strobes", {ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1}, 6'b010001);
    tick();
    check("st_c3_ack", bus1.data_mem_ack, 1'b1);
    tick();

    // Back-to-back load presented in the cycle after ack
    access1("ld_b2b", 1'b0, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF);
`ifdef DMEM_LAST_READ_BUF_EN
    access1("ld_hit", 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'hDEADBEEF);
    check("ld_hit_ce_n_high", last_ce_seen, 1'b0);
`else
    access1("ld_again", 1'b0, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF);
`endif
    access1("st_over", 1'b1, 32'h100, 32'h12345678, 4'b1111, 3, 32'h0);
    access1("ld_after_st", 1'b0, 32'h100, 32'h0, 4'h0, 3, 32'h12345678);
    check("ld_after_st_ce", last_ce_seen, 1'b1);

    access1("st_be0", 1'b1, 32'h108, 32'hFFFFFFFF, 4'b0000, 1, 32'h0);
    access1("st_lo_only", 1'b1, 32'h108, 32'h00005678, 4'b0011, 2, 32'h0);
    access1("ld_108", 1'b0, 32'h108, 32'h0, 4'h0, 3, 32'h00005678);
    access1("st_lanes", 1'b1, 32'h10C, 32'hAABBCCDD, 4'b1010, 3, 32'h0);
    access1("ld_lanes", 1'b0, 32'h10C, 32'h0, 4'h0, 3, 32'hAA00CC00);

    // Reset while in the high phase of a load
    bus1.req_M = 1'b1; bus1.we_M = 1'b0; bus1.addr_M = 32'h100;
    tick();
    tick();
    check("rh_in_hi", sram_addr1, 18'h081);
    reset = 1'b1;
    tick();
    check("rh_strobes", {ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1}, 6'b111110);
    check("rh_ack", bus1.data_mem_ack, 1'b0);
    check("rh_rdata", bus1.read_data_M, 32'h0);
    reset = 1'b0;
    bus1.req_M = 1'b0;
    tick();
    check("rh_ack_after", bus1.data_mem_ack, 1'b0);
    access1("ld_post_rst", 1'b0, 32'h100, 32'h0, 4'h0, 3, 32'h12345678);
    bus1.req_M = 1'b0;

    // WAIT_CYCLES=2: high-half-only store, then back-to-back load
    bus2.req_M = 1'b1; bus2.we_M = 1'b1; bus2.addr_M = 32'h104;
    bus2.wdata_M = 32'h00AA0000; bus2.byte_en_M = 4'b0100;
    check("w2_c0_ack", bus2.data_mem_ack, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      tick();
      check($sformatf("w2_c%0d_addr", c), sram_addr2, 18'h083);
      check($sformatf("w2_c%0d_dq", c), dq_out2, 16'h00AA);
      check($sformatf("w2_c%0d_strobes", c), {ce_n2, oe_n2, we_n2, ub_n2, lb_n2, dq_oe2}, 6'b010101);
      check($sformatf("w2_c%0d_ack", c), bus2.data_mem_ack, 1'b0);
    end
    tick();
    check("w2_c3_ack", bus2.data_mem_ack, 1'b1);
    tick();
    bus2.we_M = 1'b0;
    cyc = 0;
    while (bus2.data_mem_ack !== 1'b1 && cyc < 12) begin
      tick();
      cyc++;
    end
    check("w2_ld_ack_cycle", cyc, 5);
    check("w2_ld_rdata", bus2.read_data_M, 32'h00AA0000);
    bus2.req_M = 1'b0;
    tick();
    check("w2_ack_single", bus2.data_mem_ack, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
